// File: rtl/dvs_pkg.sv
// Shared types for the DVS event dispatcher: FSM state, event and FIFO entry layouts.
// The struct field widths describe the default build (9-bit coordinates, 16-bit timestamp).
package dvs_pkg;

  localparam int unsigned XY_BITS = 9;
  localparam int unsigned TS_BITS = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } disp_state_e;

  typedef struct packed {
    logic [XY_BITS-1:0] x;
    logic [XY_BITS-1:0] y;
    logic               pol;
  } event_t;

  typedef struct packed {
    event_t             evt;
    logic [TS_BITS-1:0] ts;
  } fifo_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dvs_event_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of two so the
// pointers wrap naturally. Pushes while full and pops while empty are ignored.
module dvs_event_fifo
  import dvs_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/dvs_event_dispatcher.sv
// Timestamps raw DVS events, buffers them and issues them one at a time with a done handshake.
// Optional range filter: define DVS_EVENT_RANGE_FILTER_EN to drop out-of-array events and expose drop_cnt.
module dvs_event_dispatcher
  import dvs_pkg::*;
#(
  parameter int unsigned CAVIAR_X_Y_BITS = 9,
  parameter int unsigned TIMESTAMP_BITS  = 16,
  parameter int unsigned DVS_WIDTH       = 346,
  parameter int unsigned DVS_HEIGHT      = 260,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned TICK_DIV        = 4,
  parameter int unsigned DONE_TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*CAVIAR_X_Y_BITS:0]   evt_in,
  input  logic                         evt_in_vld,
  output logic                         evt_in_rdy,
  output logic [2*CAVIAR_X_Y_BITS:0]   cavier_in,
  output logic                         cavier_in_vld,
  output logic [TIMESTAMP_BITS-1:0]    current_timestamp,
  output logic                         current_timestamp_vld,
  input  logic                         done,
  output logic                         busy,
  output logic                         timeout_err
`ifdef DVS_EVENT_RANGE_FILTER_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int unsigned EVT_W   = 2 * CAVIAR_X_Y_BITS + 1;
  localparam int unsigned ENTRY_W = EVT_W + TIMESTAMP_BITS;
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WAIT_W  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  disp_state_e               state_q, state_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic [PRESC_W-1:0]        presc_q, presc_d;
  logic [TIMESTAMP_BITS-1:0] ts_now_q, ts_now_d;
  logic [EVT_W-1:0]          evt_out_q, evt_out_d;
  logic [TIMESTAMP_BITS-1:0] ts_out_q, ts_out_d;
  logic                      vld_q, vld_d;
  logic                      terr_q, terr_d;

  logic                      push_s;
  logic                      store_s;
  logic                      pop_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [ENTRY_W-1:0]        fifo_rdata_s;

  // Ready is forced high during reset so upstream never sees a stale full flag.
  assign evt_in_rdy = rst | ~fifo_full_s;
  assign push_s     = evt_in_vld & evt_in_rdy & ~rst;

`ifdef DVS_EVENT_RANGE_FILTER_EN
  logic [CAVIAR_X_Y_BITS-1:0] x_s;
  logic [CAVIAR_X_Y_BITS-1:0] y_s;
  logic                       in_range_s;
  logic [15:0]                drop_q, drop_d;

  assign x_s        = evt_in[EVT_W-1 -: CAVIAR_X_Y_BITS];
  assign y_s        = evt_in[CAVIAR_X_Y_BITS:1];
  assign in_range_s = (32'(x_s) < DVS_WIDTH) && (32'(y_s) < DVS_HEIGHT);
  assign store_s    = push_s & in_range_s;
  assign drop_cnt   = drop_q;

  always_comb begin
    drop_d = drop_q;
    if (push_s && !in_range_s) begin
      drop_d = sat_inc16(drop_q);
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 16'd0;
    end else begin
      drop_q <= drop_d;
    end
  end
`else
  assign store_s = push_s;
`endif

  dvs_event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (store_s),
    .pop   (pop_s),
    .wdata ({evt_in, ts_now_q}),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  always_comb begin
    presc_d  = presc_q + PRESC_W'(1);
    ts_now_d = ts_now_q;
    if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
      presc_d  = {PRESC_W{1'b0}};
      ts_now_d = ts_now_q + TIMESTAMP_BITS'(1);
    end else begin
      ts_now_d = ts_now_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    evt_out_d = evt_out_q;
    ts_out_d  = ts_out_q;
    vld_d     = 1'b0;
    terr_d    = terr_q;
    pop_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          evt_out_d = fifo_rdata_s[ENTRY_W-1 -: EVT_W];
          ts_out_d  = fifo_rdata_s[TIMESTAMP_BITS-1:0];
          vld_d     = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        wait_d  = {WAIT_W{1'b0}};
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          state_d = IDLE;
        end else if (wait_q == WAIT_W'(DONE_TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= {WAIT_W{1'b0}};
      presc_q   <= {PRESC_W{1'b0}};
      ts_now_q  <= {TIMESTAMP_BITS{1'b0}};
      evt_out_q <= {EVT_W{1'b0}};
      ts_out_q  <= {TIMESTAMP_BITS{1'b0}};
      vld_q     <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      presc_q   <= presc_d;
      ts_now_q  <= ts_now_d;
      evt_out_q <= evt_out_d;
      ts_out_q  <= ts_out_d;
      vld_q     <= vld_d;
      terr_q    <= terr_d;
    end
  end

  assign cavier_in             = evt_out_q;
  assign current_timestamp     = ts_out_q;
  assign cavier_in_vld         = vld_q;
  assign current_timestamp_vld = vld_q;
  assign timeout_err           = terr_q;
  assign busy                  = (state_q != IDLE);

endmodule

// File: tb/tb_dvs_event_dispatcher.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
// Timestamp width is reduced to 8 bits so the wrap-around is reachable in a short run.
module tb_dvs_event_dispatcher;

  localparam int XYB  = 9;
  localparam int TSB  = 8;
  localparam int EW   = 2 * XYB + 1;
  localparam int TDIV = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [EW-1:0]  evt_in = '0;
  logic           evt_in_vld = 1'b0;
  logic           evt_in_rdy;
  logic [EW-1:0]  cavier_in;
  logic           cavier_in_vld;
  logic [TSB-1:0] current_timestamp;
  logic           current_timestamp_vld;
  logic           done = 1'b0;
  logic           busy;
  logic           timeout_err;
`ifdef DVS_EVENT_RANGE_FILTER_EN
  logic [15:0]    drop_cnt;
`endif

  dvs_event_dispatcher #(
    .CAVIAR_X_Y_BITS (XYB),
    .TIMESTAMP_BITS  (TSB),
    .TICK_DIV        (TDIV)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .evt_in                (evt_in),
    .evt_in_vld            (evt_in_vld),
    .evt_in_rdy            (evt_in_rdy),
    .cavier_in             (cavier_in),
    .cavier_in_vld         (cavier_in_vld),
    .current_timestamp     (current_timestamp),
    .current_timestamp_vld (current_timestamp_vld),
    .done                  (done),
    .busy                  (busy),
    .timeout_err           (timeout_err)
`ifdef DVS_EVENT_RANGE_FILTER_EN
    ,
    .drop_cnt              (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [EW-1:0]  evt;
    logic [TSB-1:0] ts;
  } exp_t;

  exp_t           sb[$];
  int             strobe_cyc[$];
  logic [TSB-1:0] strobe_ts[$];
  logic [EW-1:0]  strobe_evt[$];
  int             n_checks = 0;
  int             n_errors = 0;
  int             n_edges = 0;
  int             cyc_no = 0;
  int             done_timer = -1;
  bit             auto_done = 1'b1;
  int             skip_pct = 0;
  int             drop_model = 0;

  // Non-reset rising edges since the last reset; timestamp = edges / TICK_DIV.
  always @(posedge clk) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TSB-1:0] ts_model();
    return TSB'(n_edges / TDIV);
  endfunction

  function automatic logic [EW-1:0] rnd_in_range();
    return {9'($urandom_range(0, 345)), 9'($urandom_range(0, 259)), 1'($urandom_range(0, 1))};
  endfunction

  task automatic monitor();
    exp_t e;
    if (cavier_in_vld || current_timestamp_vld) begin
      check("vld_pair", 32'(current_timestamp_vld), 32'(cavier_in_vld));
      if (sb.size() == 0) begin
        check("spurious_strobe", 32'(cavier_in_vld), 32'd0);
      end else begin
        e = sb.pop_front();
        check("evt_order", 32'(cavier_in), 32'(e.evt));
        check("evt_ts", 32'(current_timestamp), 32'(e.ts));
      end
      strobe_cyc.push_back(cyc_no);
      strobe_ts.push_back(current_timestamp);
      strobe_evt.push_back(cavier_in);
      if (auto_done)
        done_timer = (int'($urandom_range(0, 99)) < skip_pct) ? -1 : int'($urandom_range(1, 5));
    end
  endtask

  // Drive one cycle, record any accepted event in the model, then sample after the edge.
  task automatic cyc(input bit v, input logic [EW-1:0] e);
    evt_in_vld = v;
    evt_in     = e;
    done       = (done_timer == 0);
    if (done_timer >= 0) done_timer--;
    if (v && evt_in_rdy && !rst) begin
`ifdef DVS_EVENT_RANGE_FILTER_EN
      if (32'(e[EW-1:XYB+1]) >= 32'd346 || 32'(e[XYB:1]) >= 32'd260) begin
        if (drop_model != 65535) drop_model++;
      end else begin
        sb.push_back('{evt: e, ts: ts_model()});
      end
`else
      sb.push_back('{evt: e, ts: ts_model()});
`endif
    end
    @(posedge clk);
    #1;
    cyc_no++;
    monitor();
  endtask

  task automatic run_until_strobes(input int target, input int budget);
    int b = budget;
    while (strobe_cyc.size() < target && b > 0) begin
      cyc(1'b0, '0);
      b--;
    end
    if (strobe_cyc.size() < target) check("strobe_wait", 32'(strobe_cyc.size()), 32'(target));
  endtask

  task automatic drain(input int budget);
    int b = budget;
    while (sb.size() > 0 && b > 0) begin
      cyc(1'b0, '0);
      b--;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, '0);
    check("rdy_in_reset", 32'(evt_in_rdy), 32'd1);
    cyc(1'b0, '0);
    rst = 1'b0;
    sb.delete();
    strobe_cyc.delete();
    strobe_ts.delete();
    strobe_evt.delete();
    done_timer = -1;
    drop_model = 0;
    check("rst_vld", 32'(cavier_in_vld), 32'd0);
    check("rst_ts_vld", 32'(current_timestamp_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_evt", 32'(cavier_in), 32'd0);
    check("rst_ts", 32'(current_timestamp), 32'd0);
  endtask

  initial begin
    int push_c;
    int s;
    int c0;
    int acc;
    int b;
    int base;
    logic [EW-1:0] ev;

    // Reset state and a single event with done three cycles after the strobe.
    do_reset();
    check("rdy_after_reset", 32'(evt_in_rdy), 32'd1);
    auto_done = 1'b0;
    while (n_edges < 20) cyc(1'b0, '0);
    push_c = cyc_no;
    cyc(1'b1, {9'd10, 9'd20, 1'b1});
    run_until_strobes(1, 10);
    if (strobe_cyc.size() >= 1) begin
      check("single_latency", 32'(strobe_cyc[0] - push_c), 32'd2);
      check("single_evt", 32'(strobe_evt[0]), 32'({9'd10, 9'd20, 1'b1}));
      check("single_ts", 32'(strobe_ts[0]), 32'd5);
      s = strobe_cyc[0];
      done_timer = 3;
      while (cyc_no < s + 3) cyc(1'b0, '0);
      check("busy_at_done", 32'(busy), 32'd1);
      cyc(1'b0, '0);
      check("busy_after_done", 32'(busy), 32'd0);
    end

    // Timestamp wrap: pushes at ts 0xFE, 0xFF, 0x00.
    auto_done = 1'b1;
    skip_pct  = 0;
    while (n_edges < 1016) cyc(1'b0, '0);
    base = strobe_cyc.size();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, rnd_in_range());
      for (int j = 0; j < 3; j++) cyc(1'b0, '0);
    end
    run_until_strobes(base + 3, 40);
    if (strobe_cyc.size() >= base + 3) begin
      check("wrap_ts0", 32'(strobe_ts[base]), 32'h0FE);
      check("wrap_ts1", 32'(strobe_ts[base + 1]), 32'h0FF);
      check("wrap_ts2", 32'(strobe_ts[base + 2]), 32'h000);
    end

    // Event outside the sensor array.
    base = strobe_cyc.size();
    cyc(1'b1, {9'd346, 9'd0, 1'b0});
`ifdef DVS_EVENT_RANGE_FILTER_EN
    for (int j = 0; j < 12; j++) cyc(1'b0, '0);
    check("filter_no_strobe", 32'(strobe_cyc.size()), 32'(base));
    check("filter_drop_cnt", 32'(drop_cnt), 32'd1);
`else
    run_until_strobes(base + 1, 12);
    if (strobe_cyc.size() >= base + 1)
      check("nofilter_evt", 32'(strobe_evt[base]), 32'({9'd346, 9'd0, 1'b0}));
`endif
    drain(50);

    // Fill the FIFO with no done; the first event times out and frees a slot.
    do_reset();
    auto_done = 1'b0;
    c0 = cyc_no;
    for (int i = 0; i < 9; i++) begin
      check("rdy_fill", 32'(evt_in_rdy), 32'd1);
      cyc(1'b1, rnd_in_range());
    end
    check("rdy_full", 32'(evt_in_rdy), 32'd0);
    ev  = rnd_in_range();
    acc = -1;
    b   = 150;
    while (acc < 0 && b > 0) begin
      if (evt_in_rdy) acc = cyc_no;
      cyc(1'b1, ev);
      b--;
    end
    check("held_accept_cycle", 32'(acc - c0), 32'd68);
    if (strobe_cyc.size() >= 2) check("timeout_spacing", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd66);
    else check("timeout_second_strobe", 32'(strobe_cyc.size()), 32'd2);
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    auto_done = 1'b1;
    drain(400);
    for (int j = 0; j < 8; j++) cyc(1'b0, '0);
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Reset while an event is in WAIT_DONE with more queued.
    do_reset();
    auto_done = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, rnd_in_range());
    run_until_strobes(1, 10);
    for (int j = 0; j < 3; j++) cyc(1'b0, '0);
    check("busy_before_rst", 32'(busy), 32'd1);
    do_reset();
    for (int j = 0; j < 20; j++) cyc(1'b0, '0);
    check("post_rst_no_strobe", 32'(strobe_cyc.size()), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_rdy", 32'(evt_in_rdy), 32'd1);
    auto_done = 1'b1;
    push_c = cyc_no;
    cyc(1'b1, rnd_in_range());
    run_until_strobes(1, 10);
    if (strobe_cyc.size() >= 1) check("post_rst_latency", 32'(strobe_cyc[0] - push_c), 32'd2);
    drain(50);

    // Random traffic with random done delays and occasional timeouts.
    do_reset();
    auto_done = 1'b1;
    skip_pct  = 10;
    for (int i = 0; i < 800; i++) begin
      ev = EW'($urandom);
      cyc(1'($urandom_range(0, 1)), ev);
    end
    drain(2000);
    check("rand_some_strobes", 32'(strobe_cyc.size() > 20), 32'd1);
`ifdef DVS_EVENT_RANGE_FILTER_EN
    check("rand_drop_cnt", 32'(drop_cnt), 32'(drop_model));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
